// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding, x0 index, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_ctrl_pkg;

   // Memory handshake FSM: RUN while the data memory keeps up, MEM_WAIT while an access is outstanding.
   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   // Register x0 is hard-wired to zero, so a load targeting it never creates a dependency.
   localparam logic [4:0] REG_X0 = 5'd0;

   // Default number of consecutive cycles without mem_ready before an access is abandoned.
   localparam int DEF_MEM_TIMEOUT = 16;

   // Default width of the stall/flush performance counters.
   localparam int DEF_CNT_W = 16;

   // True when the load sitting in EX writes a register the instruction in ID reads.
   function automatic logic load_use_hit(
      input logic       mem_read,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2
   );
      return mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard inputs from the pipe and enable/flush/status outputs of the controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; the controller itself freezes the pipe through the write enables.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   // Hazard sources observed in the pipe
   logic             ID_EX_MemRead;
   logic [4:0]       ID_EX_RD;
   logic [4:0]       IF_ID_RS1;
   logic [4:0]       IF_ID_RS2;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;

   // Pipe register controls
   logic             PC_write;
   logic             IF_ID_write;
   logic             IF_ID_flush;
   logic             ID_EX_write;
   logic             ID_EX_flush;
   logic             EX_MEM_write;
   logic             MEM_WB_write;
   logic             MEM_WB_flush;

   // Status and performance counters
   logic             mem_error;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_cycles;

   // Pipeline side: drives hazard sources, consumes the controls
   modport master (
      output ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2,
      output branch_taken, mem_req, mem_ready,
      input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
      input  EX_MEM_write, MEM_WB_write, MEM_WB_flush,
      input  mem_error, stall_cycles, flush_cycles
   );

   // Controller side: consumes hazard sources, drives the controls
   modport slave (
      input  ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2,
      input  branch_taken, mem_req, mem_ready,
      output PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
      output EX_MEM_write, MEM_WB_write, MEM_WB_flush,
      output mem_error, stall_cycles, flush_cycles
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects events up to the previous clock edge.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Hold at all-ones instead of wrapping so a long run never reads back as a small number.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC/IF_ID/ID_EX/EX_MEM/MEM_WB enables and flushes for load-use, branch, memory wait.
// Latency: controls are combinational from current state and inputs; status/counters are registered.
// Backpressure: a slow data memory freezes PC..EX_MEM and bubbles MEM_WB until mem_ready or timeout.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave ctrl_if
);

   // The wait counter only has to reach MEM_TIMEOUT-1; keep at least one bit.
   localparam int                WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_e            state_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic              mem_error_q;

   logic mem_miss;
   logic timeout;
   logic mem_stall;
   logic branch_flush;
   logic load_use;

   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_write;
   logic id_ex_flush;
   logic ex_mem_write;
   logic mem_wb_write;
   logic mem_wb_flush;

   // Classify this cycle's hazard; reset forces the plain RUN behaviour.
   always_comb begin
      mem_miss     = ctrl_if.mem_req && !ctrl_if.mem_ready;
      // The wait counter already includes the RUN cycle that first missed, so the
      // (MEM_TIMEOUT)th consecutive cycle without mem_ready is the one that gives up.
      timeout      = (state_q == MEM_WAIT) && !ctrl_if.mem_ready && (wait_cnt_q >= WAIT_LAST);
      mem_stall    = !reset &&
                     (((state_q == RUN) && mem_miss) ||
                      ((state_q == MEM_WAIT) && !ctrl_if.mem_ready && !timeout));
      // A branch seen while frozen is ignored: EX holds it and presents it again on release.
      branch_flush = !reset && !mem_stall && ctrl_if.branch_taken;
      load_use     = !reset && !mem_stall && !ctrl_if.branch_taken &&
                     load_use_hit(ctrl_if.ID_EX_MemRead, ctrl_if.ID_EX_RD,
                                  ctrl_if.IF_ID_RS1, ctrl_if.IF_ID_RS2);
   end

   // Translate the winning hazard into enables and flushes (memory stall > branch > load-use).
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      mem_wb_flush = 1'b0;
      if (mem_stall) begin
         // Freeze everything up to EX_MEM; MEM_WB takes a bubble so the frozen
         // instruction in MEM does not write back twice.
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (branch_flush) begin
         // Squash the two wrong-path instructions in IF and ID.
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
      end else if (load_use) begin
         // Hold PC and IF_ID one cycle and insert a bubble; the bubble clears
         // ID_EX_MemRead so the stall cannot repeat.
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_flush  = 1'b1;
      end
   end

   // Memory handshake FSM with wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         mem_error_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_miss) begin
                  state_q    <= MEM_WAIT;
                  wait_cnt_q <= WAIT_W'(1);
               end else begin
                  wait_cnt_q <= '0;
               end
            end
            MEM_WAIT: begin
               if (ctrl_if.mem_ready) begin
                  state_q    <= RUN;
                  wait_cnt_q <= '0;
               end else if (timeout) begin
                  state_q     <= RUN;
                  wait_cnt_q  <= '0;
                  mem_error_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q    <= RUN;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!pc_write),
      .count (ctrl_if.stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (branch_flush),
      .count (ctrl_if.flush_cycles)
   );

   assign ctrl_if.PC_write     = pc_write;
   assign ctrl_if.IF_ID_write  = if_id_write;
   assign ctrl_if.IF_ID_flush  = if_id_flush;
   assign ctrl_if.ID_EX_write  = id_ex_write;
   assign ctrl_if.ID_EX_flush  = id_ex_flush;
   assign ctrl_if.EX_MEM_write = ex_mem_write;
   assign ctrl_if.MEM_WB_write = mem_wb_write;
   assign ctrl_if.MEM_WB_flush = mem_wb_flush;
   assign ctrl_if.mem_error    = mem_error_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed vectors go to a scoreboard queue, a monitor compares.
// Latency: one vector per cycle, checked at the falling edge of the cycle it was applied.
// Backpressure: none; the driver never waits on the DUT except for a bounded drain at the end.
module tb_pipe_hazard_ctrl;

   localparam int TB_CNT_W   = 4;
   localparam int TB_TIMEOUT = 4;

   // Control order: PC_w, IF_ID_w, IF_ID_f, ID_EX_w, ID_EX_f, EX_MEM_w, MEM_WB_w, MEM_WB_f
   localparam logic [7:0] C_DEF = 8'b1101_0110;
   localparam logic [7:0] C_LU  = 8'b0001_1110;
   localparam logic [7:0] C_BR  = 8'b1111_1110;
   localparam logic [7:0] C_MS  = 8'b0000_0011;

   typedef struct {
      int                  id;
      logic [7:0]          ctl;
      logic                err;
      logic [TB_CNT_W-1:0] st;
      logic [TB_CNT_W-1:0] fl;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors_applied = 0;
   int   miscompares     = 0;
   int   vec_id          = 0;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic [7:0] ctl_obs;

   pipe_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .ctrl_if (bus)
   );

   always #5 clk = ~clk;

   assign ctl_obs = {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_write,
                     bus.ID_EX_flush, bus.EX_MEM_write, bus.MEM_WB_write, bus.MEM_WB_flush};

   // Monitor: compare the DUT against the oldest pending expectation, mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         vectors_applied++;
         if (ctl_obs !== mon_e.ctl || bus.mem_error !== mon_e.err ||
             bus.stall_cycles !== mon_e.st || bus.flush_cycles !== mon_e.fl) begin
            miscompares++;
            $display("FAIL vec%0d: got ctl=%b err=%b stall=%0d flush=%0d, want ctl=%b err=%b stall=%0d flush=%0d",
                     mon_e.id, ctl_obs, bus.mem_error, bus.stall_cycles, bus.flush_cycles,
                     mon_e.ctl, mon_e.err, mon_e.st, mon_e.fl);
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge and queue what the DUT must show.
   task automatic apply(input logic rst, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                        input logic req, input logic rdy, input logic [7:0] ctl,
                        input logic err, input int st, input int fl);
      exp_t e;
      @(posedge clk);
      #1;
      reset             = rst;
      bus.ID_EX_MemRead = mr;
      bus.ID_EX_RD      = rd;
      bus.IF_ID_RS1     = rs1;
      bus.IF_ID_RS2     = rs2;
      bus.branch_taken  = br;
      bus.mem_req       = req;
      bus.mem_ready     = rdy;
      e.id  = vec_id;
      e.ctl = ctl;
      e.err = err;
      e.st  = TB_CNT_W'(st);
      e.fl  = TB_CNT_W'(fl);
      vec_id++;
      exp_q.push_back(e);
   endtask

   initial begin
      bus.ID_EX_MemRead = 1'b0;
      bus.ID_EX_RD      = 5'd0;
      bus.IF_ID_RS1     = 5'd0;
      bus.IF_ID_RS2     = 5'd0;
      bus.branch_taken  = 1'b0;
      bus.mem_req       = 1'b0;
      bus.mem_ready     = 1'b0;

      //    rst mr  rd     rs1    rs2    br  req rdy  ctl    err st  fl
      // Reset: outputs stay at the RUN default even with hazards present
      apply(1, 1, 5'd5,  5'd5,  5'd0,  1, 1, 0, C_DEF, 0, 0,  0);
      apply(1, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 0,  0);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 0,  0);
      // Load-use on rs1 for exactly one cycle
      apply(0, 1, 5'd5,  5'd5,  5'd0,  0, 0, 0, C_LU,  0, 0,  0);
      apply(0, 0, 5'd5,  5'd5,  5'd0,  0, 0, 0, C_DEF, 0, 1,  0);
      // Load to x0 never stalls
      apply(0, 1, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 1,  0);
      // Load-use on rs2
      apply(0, 1, 5'd9,  5'd3,  5'd9,  0, 0, 0, C_LU,  0, 1,  0);
      apply(0, 0, 5'd9,  5'd3,  5'd9,  0, 0, 0, C_DEF, 0, 2,  0);
      // Branch together with load-use: branch wins
      apply(0, 1, 5'd7,  5'd7,  5'd0,  1, 0, 0, C_BR,  0, 2,  0);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 2,  1);
      // Memory wait of three cycles, branch ignored while frozen, released by mem_ready
      // on the last permitted cycle (no error); the re-presented branch then flushes
      apply(0, 0, 5'd0,  5'd0,  5'd0,  1, 1, 0, C_MS,  0, 2,  1);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  1, 1, 0, C_MS,  0, 3,  1);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_MS,  0, 4,  1);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  1, 1, 1, C_BR,  0, 5,  1);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 5,  2);
      // Timeout: three stall cycles, release on the fourth, sticky error afterwards
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_MS,  0, 5,  2);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_MS,  0, 6,  2);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_MS,  0, 7,  2);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_DEF, 0, 8,  2);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 1, 8,  2);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 1, 8,  2);
      // Reset in the middle of a wait: back to RUN, counters and error cleared
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_MS,  1, 8,  2);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_MS,  1, 9,  2);
      apply(1, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_DEF, 1, 10, 2);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 0,  0);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  1, 0, 0, C_BR,  0, 0,  0);
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 0,  1);
      // Stall counter saturation: hazard held on every cycle, counter stops at 15
      for (int k = 0; k < 18; k++) begin
         apply(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, C_LU, 0, (k > 15) ? 15 : k, 1);
      end
      apply(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 15, 1);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
